// File: rtl/extend_arbiter.sv
// Round-robin arbiter sharing one external 16->32 extend unit between N_REQ requesters.
// Each granted result is registered together with the requester ID behind a valid/ready output slot.
module extend_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned ID_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*IN_W-1:0]   req_a,
    input  logic [N_REQ-1:0]        req_sext,
    output logic [IN_W-1:0]         ext_a,
    output logic                    ext_sext,
    input  logic [OUT_W-1:0]        ext_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_b,
    output logic [ID_W-1:0]         out_id,
    output logic [CNT_W-1:0]        xfer_cnt
);

    typedef enum logic {IDLE, FULL} state_t;

    state_t            state_q, state_d;
    logic [OUT_W-1:0]  out_b_q, out_b_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              slot_free;
    logic              found;
    logic [ID_W-1:0]   gnt_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            out_b_q  <= '0;
            out_id_q <= '0;
            last_q   <= ID_W'(N_REQ - 1);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_b_q  <= out_b_d;
            out_id_q <= out_id_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (found) state_d = FULL;
            FULL:    if (out_ready && !found) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == FULL);
        out_b     = out_b_q;
        out_id    = out_id_q;
        xfer_cnt  = cnt_q;
    end

    assign slot_free = !out_valid || out_ready;

    // Search starts one past the last grant; first valid hit wins.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] cand;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        cand    = '0;
        if (slot_free && !rst) begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                idx  = (32'(last_q) + k) % N_REQ;
                cand = ID_W'(idx);
                if (!found && req_valid[cand]) begin
                    found   = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        ext_a     = '0;
        ext_sext  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (found && gnt_idx == ID_W'(i)) begin
                req_ready[i] = 1'b1;
                ext_a        = req_a[i*IN_W +: IN_W];
                ext_sext     = req_sext[i];
            end
        end
    end

    always_comb begin
        out_b_d  = out_b_q;
        out_id_d = out_id_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        if (found) begin
            out_b_d  = ext_b;
            out_id_d = gnt_idx;
            last_d   = gnt_idx;
            cnt_d    = cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_extend_arbiter.sv
// Directed bench for extend_arbiter: two requesters, real extend unit on ext_*, CNT_W=4 so wrap is reachable.
module tb_extend_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] a0, a1;
    logic [1:0]  req_sext;
    logic [15:0] ext_a;
    logic        ext_sext;
    logic [31:0] ext_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_b;
    logic [0:0]  out_id;
    logic [3:0]  xfer_cnt;

    int total = 0;
    int bad   = 0;

    extend_arbiter #(.N_REQ(2), .IN_W(16), .OUT_W(32), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     ({a1, a0}),
        .req_sext  (req_sext),
        .ext_a     (ext_a),
        .ext_sext  (ext_sext),
        .ext_b     (ext_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_id    (out_id),
        .xfer_cnt  (xfer_cnt)
    );

    // The shared extend unit that lives outside the arbiter.
    assign ext_b = ext_sext ? {{16{ext_a[15]}}, ext_a} : {16'h0000, ext_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  vld;
        logic [15:0] va0;
        logic [15:0] va1;
        logic [1:0]  sx;
        logic        ordy;
        logic [1:0]  e_rdy;
        logic        e_vld;
        logic [31:0] e_b;
        logic        e_id;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] a;
        logic        s, r;
        logic [31:0] e;

        tv[0] = '{2'b01, 16'h8000, 16'h0000, 2'b01, 1'b1, 2'b01, 1'b1, 32'hFFFF8000, 1'b0, 4'd1};
        tv[1] = '{2'b10, 16'h0000, 16'hFFFF, 2'b00, 1'b1, 2'b10, 1'b1, 32'h0000FFFF, 1'b1, 4'd2};
        tv[2] = '{2'b10, 16'h0000, 16'h7FFF, 2'b10, 1'b1, 2'b10, 1'b1, 32'h00007FFF, 1'b1, 4'd3};
        tv[3] = '{2'b01, 16'h1234, 16'h0000, 2'b00, 1'b1, 2'b01, 1'b1, 32'h00001234, 1'b0, 4'd4};
        tv[4] = '{2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 2'b00, 1'b0, 32'h00001234, 1'b0, 4'd4};
        tv[5] = '{2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 32'h00001234, 1'b0, 4'd4};
        tv[6] = '{2'b11, 16'h00FF, 16'h8001, 2'b11, 1'b0, 2'b10, 1'b1, 32'hFFFF8001, 1'b1, 4'd5};
        tv[7] = '{2'b11, 16'h00FF, 16'h8001, 2'b11, 1'b0, 2'b00, 1'b1, 32'hFFFF8001, 1'b1, 4'd5};
        tv[8] = '{2'b11, 16'h00FF, 16'h8001, 2'b11, 1'b1, 2'b01, 1'b1, 32'h000000FF, 1'b0, 4'd6};

        // Reset state, with a request already pending.
        rst = 1'b1; req_valid = 2'b01; a0 = 16'h8000; a1 = '0; req_sext = 2'b01; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_b",     out_b,          32'h0);
        chk("rst_id",    32'(out_id),    32'h0);
        chk("rst_cnt",   32'(xfer_cnt),  32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            req_valid = tv[i].vld; a0 = tv[i].va0; a1 = tv[i].va1;
            req_sext = tv[i].sx; out_ready = tv[i].ordy;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tv[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tv[i].e_vld));
            chk($sformatf("v%0d_b", i),     out_b,          tv[i].e_b);
            chk($sformatf("v%0d_id", i),    32'(out_id),    32'(tv[i].e_id));
            chk($sformatf("v%0d_cnt", i),   32'(xfer_cnt),  32'(tv[i].e_cnt));
        end

        // Both requesters held valid: strict alternation, back-to-back output.
        req_valid = '0;
        do_reset();
        req_valid = 2'b11; a0 = 16'h0001; a1 = 16'h0002; req_sext = 2'b00; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("rr%0d_ready", c), 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_valid", c), 32'(out_valid), 32'h1);
            chk($sformatf("rr%0d_id", c),    32'(out_id),    32'(c % 2));
            chk($sformatf("rr%0d_b", c),     out_b,          (c % 2 == 0) ? 32'h1 : 32'h2);
        end
        chk("rr_cnt", 32'(xfer_cnt), 32'd6);

        // Stall: output held, no grants; release grants next in RR order same cycle.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_ready", c), 32'(req_ready), 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d_valid", c), 32'(out_valid), 32'h1);
            chk($sformatf("stall%0d_id", c),    32'(out_id),    32'h1);
            chk($sformatf("stall%0d_b", c),     out_b,          32'h2);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("unstall_id",  32'(out_id),   32'h0);
        chk("unstall_b",   out_b,         32'h1);
        chk("unstall_cnt", 32'(xfer_cnt), 32'd7);

        // Asynchronous reset mid-stream.
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_cnt",   32'(xfer_cnt),  32'h0);
        chk("arst_ready", 32'(req_ready), 32'h0);
        chk("arst_b",     out_b,          32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("post_rst_id",  32'(out_id),   32'h0);
        chk("post_rst_cnt", 32'(xfer_cnt), 32'd1);

        // 17 single transfers on a 4-bit counter: wraps to 1.
        req_valid = '0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            r = 1'(i % 2);
            s = (i % 3) != 0;
            a = 16'(i * 16'h1357 + 16'h7F01);
            e = s ? {{16{a[15]}}, a} : {16'h0000, a};
            req_valid = r ? 2'b10 : 2'b01;
            a0 = r ? 16'h0 : a;
            a1 = r ? a : 16'h0;
            req_sext = r ? {s, 1'b0} : {1'b0, s};
            #1;
            chk($sformatf("w%0d_ready", i), 32'(req_ready), r ? 32'h2 : 32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("w%0d_valid", i), 32'(out_valid), 32'h1);
            chk($sformatf("w%0d_b", i),     out_b,          e);
            chk($sformatf("w%0d_id", i),    32'(out_id),    32'(r));
        end
        chk("wrap_cnt", 32'(xfer_cnt), 32'd1);

        req_valid = '0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
